rggen_indirect_access_initiator: RTL

RGGEN_INDIRECT_ACCESS_INITIATOR -- requirements
Module: rggen_indirect_access_initiator

---
 rtl/rggen_indirect_access_initiator_pkg.sv | 33 +++
 rtl/rggen_indirect_access_initiator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rggen_indirect_access_initiator_pkg.sv
// Shared definitions for the indirect access initiator.
// Holds the register-bus access and status encodings, the FSM state type, and a
// helper that classifies a bus status as an error.
package rggen_indirect_access_initiator_pkg;

  // Register bus access encodings
  localparam logic [1:0] RggenRead  = 2'b10;
  localparam logic [1:0] RggenWrite = 2'b11;

  // Register bus status encodings
  localparam logic [1:0] RggenOkay        = 2'b00;
  localparam logic [1:0] RggenExokay      = 2'b01;
  localparam logic [1:0] RggenSlaveError  = 2'b10;
  localparam logic [1:0] RggenDecodeError = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIndex,
    StData,
    StRsp
  } state_e;

  function automatic logic is_error(input logic [1:0] status);
    logic err;
    case (status)
      RggenOkay, RggenExokay:           err = 1'b0;
      RggenSlaveError, RggenDecodeError: err = 1'b1;
      default:                           err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/rggen_indirect_access_initiator.sv
// Indirect register access initiator.
// Turns a command (read/write of one indexed entry) into a two-phase register bus
// sequence: first a write of the index to INDEX_ADDRESS, then a read or write at
// DATA_ADDRESS. The final bus status (and read data for reads) is returned on the
// response channel.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cmd_*, o_cmd_ready    command channel (accepted only in IDLE)
//   o_rsp_*, i_rsp_ready    response channel (valid only in RSP)
//   o_register_*            register bus request (valid in INDEX and DATA)
//   i_register_*            register bus completion, status and read data
//
// Optional feature: define RGGEN_INDIRECT_INDEX_CACHE_EN to remember the last
// successfully written index; a command to the same index then skips the index phase.
module rggen_indirect_access_initiator
  import rggen_indirect_access_initiator_pkg::*;
#(
  parameter int          ADDRESS_WIDTH        = 8,
  parameter int          BUS_WIDTH            = 32,
  parameter int          INDIRECT_INDEX_WIDTH = 8,
  parameter int unsigned INDEX_ADDRESS        = 0,
  parameter int unsigned DATA_ADDRESS         = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_write,
  input  logic [INDIRECT_INDEX_WIDTH-1:0] i_cmd_index,
  input  logic [BUS_WIDTH-1:0]            i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]          i_cmd_strobe,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic [BUS_WIDTH-1:0]            o_rsp_read_data,
  output logic [1:0]                      o_rsp_status,
  output logic                            o_register_valid,
  output logic [1:0]                      o_register_access,
  output logic [ADDRESS_WIDTH-1:0]        o_register_address,
  output logic [BUS_WIDTH-1:0]            o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]          o_register_strobe,
  input  logic                            i_register_ready,
  input  logic [1:0]                      i_register_status,
  input  logic [BUS_WIDTH-1:0]            i_register_read_data
);

  localparam int StrbW = BUS_WIDTH / 8;

  state_e                          state_q, state_d;
  logic                            cmd_write_q, cmd_write_d;
  logic [INDIRECT_INDEX_WIDTH-1:0] cmd_index_q, cmd_index_d;
  logic [BUS_WIDTH-1:0]            cmd_wdata_q, cmd_wdata_d;
  logic [StrbW-1:0]                cmd_strobe_q, cmd_strobe_d;
  logic [BUS_WIDTH-1:0]            rsp_data_q, rsp_data_d;
  logic [1:0]                      rsp_status_q, rsp_status_d;
`ifdef RGGEN_INDIRECT_INDEX_CACHE_EN
  logic [INDIRECT_INDEX_WIDTH-1:0] cache_index_q, cache_index_d;
  logic                            cache_valid_q, cache_valid_d;
`endif

  // Next-state and capture logic. i_register_ready only matters in INDEX/DATA.
  always_comb begin
    state_d      = state_q;
    cmd_write_d  = cmd_write_q;
    cmd_index_d  = cmd_index_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_strobe_d = cmd_strobe_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
`ifdef RGGEN_INDIRECT_INDEX_CACHE_EN
    cache_index_d = cache_index_q;
    cache_valid_d = cache_valid_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          cmd_write_d  = i_cmd_write;
          cmd_index_d  = i_cmd_index;
          cmd_wdata_d  = i_cmd_write_data;
          cmd_strobe_d = i_cmd_strobe;
          state_d      = StIndex;
`ifdef RGGEN_INDIRECT_INDEX_CACHE_EN
          if (cache_valid_q && (cache_index_q == i_cmd_index)) begin
            state_d = StData;
          end
`endif
        end
      end
      StIndex: begin
        if (i_register_ready) begin
          if (is_error(i_register_status)) begin
            // Index write failed: report it and skip the data phase.
            state_d      = StRsp;
            rsp_status_d = i_register_status;
            rsp_data_d   = '0;
`ifdef RGGEN_INDIRECT_INDEX_CACHE_EN
            cache_valid_d = 1'b0;
`endif
          end else begin
            state_d = StData;
`ifdef RGGEN_INDIRECT_INDEX_CACHE_EN
            cache_valid_d = 1'b1;
            cache_index_d = cmd_index_q;
`endif
          end
        end
      end
      StData: begin
        if (i_register_ready) begin
          state_d      = StRsp;
          rsp_status_d = i_register_status;
          rsp_data_d   = cmd_write_q ? '0 : i_register_read_data;
        end
      end
      StRsp: begin
        if (i_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus request is a pure function of state and held captures, so it stays stable
  // for as long as the bus stalls.
  always_comb begin
    o_register_valid      = 1'b0;
    o_register_access     = 2'b00;
    o_register_address    = '0;
    o_register_write_data = '0;
    o_register_strobe     = '0;
    unique case (state_q)
      StIndex: begin
        o_register_valid      = 1'b1;
        o_register_access     = RggenWrite;
        o_register_address    = ADDRESS_WIDTH'(INDEX_ADDRESS);
        o_register_write_data[INDIRECT_INDEX_WIDTH-1:0] = cmd_index_q;
        o_register_strobe     = '1;
      end
      StData: begin
        o_register_valid   = 1'b1;
        o_register_address = ADDRESS_WIDTH'(DATA_ADDRESS);
        if (cmd_write_q) begin
          o_register_access     = RggenWrite;
          o_register_write_data = cmd_wdata_q;
          o_register_strobe     = cmd_strobe_q;
        end else begin
          o_register_access = RggenRead;
        end
      end
      default: ;
    endcase
  end

  assign o_cmd_ready     = (state_q == StIdle);
  assign o_rsp_valid     = (state_q == StRsp);
  assign o_rsp_read_data = rsp_data_q;
  assign o_rsp_status    = rsp_status_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      cmd_write_q  <= 1'b0;
      cmd_index_q  <= '0;
      cmd_wdata_q  <= '0;
      cmd_strobe_q <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= RggenOkay;
`ifdef RGGEN_INDIRECT_INDEX_CACHE_EN
      cache_index_q <= '0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_write_q  <= cmd_write_d;
      cmd_index_q  <= cmd_index_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_strobe_q <= cmd_strobe_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
`ifdef RGGEN_INDIRECT_INDEX_CACHE_EN
      cache_index_q <= cache_index_d;
      cache_valid_q <= cache_valid_d;
`endif
    end
  end

endmodule
